// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_pkg
// Description : Shared opcode typedefs for the pipelined ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pipe_pkg;

  typedef logic [3:0] opcode_t;

  typedef enum logic [3:0] {
    PASS_A = 4'h0,
    PASS_B = 4'h1,
    ADD    = 4'h2,
    SUB    = 4'h3,
    AND    = 4'h4,
    OR     = 4'h5,
    XOR    = 4'h6,
    MUL    = 4'h7
  } alu_op_t;

  function automatic logic is_mul_op(input alu_op_t op);
    return op == MUL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Sequential shift-add multiplier, one partial product per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  // done stays high for the single cycle between the last step and collection
  assign done    = busy_q && (cnt_q == '0);
  assign product = prod_q;

  always_comb begin
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
      cnt_d    = CNT_W'(WIDTH);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Valid/ready ALU with registered result; define ALU_MUL_EN to
//               build in the multi-cycle MUL via alu_mul_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             res_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               carry_q, carry_d;
  logic               res_zero_q, res_zero_d;

  logic               accept;
  logic               go_calc;
  logic [WIDTH-1:0]   alu_out;
  logic               alu_carry;
  logic [WIDTH:0]     sum, diff;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign zero      = (accum == '0);
  assign out       = out_q;
  assign carry     = carry_q;
  assign res_zero  = res_zero_q;

`ifdef ALU_MUL_EN
  assign go_calc = is_mul_op(op);

  alu_mul_seq #(
    .WIDTH   (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_),
    .start   (accept && go_calc),
    .a       (accum),
    .b       (data),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign go_calc  = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  // MUL and undefined encodings fall through to PASS_A here
  always_comb begin
    alu_out   = accum;
    alu_carry = 1'b0;
    sum       = {1'b0, accum} + {1'b0, data};
    diff      = {1'b0, accum} - {1'b0, data};
    case (op)
      PASS_B:  alu_out = data;
      ADD:     {alu_carry, alu_out} = sum;
      SUB:     {alu_carry, alu_out} = diff;
      AND:     alu_out = accum & data;
      OR:      alu_out = accum | data;
      XOR:     alu_out = accum ^ data;
      default: alu_out = accum;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    carry_d    = carry_q;
    res_zero_d = res_zero_q;
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          if (go_calc) begin
            state_d = CALC;
          end else begin
            state_d    = HOLD;
            out_d      = alu_out;
            carry_d    = alu_carry;
            res_zero_d = (alu_out == '0);
          end
        end else if (state_q == HOLD && out_ready) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (mul_done) begin
          state_d    = HOLD;
          out_d      = mul_prod[WIDTH-1:0];
          carry_d    = |mul_prod[2*WIDTH-1:WIDTH];
          res_zero_d = (mul_prod[WIDTH-1:0] == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      out_q      <= '0;
      carry_q    <= 1'b0;
      res_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      carry_q    <= carry_d;
      res_zero_q <= res_zero_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Directed self-checking bench for alu_pipe (WIDTH=8); MUL
//               scenarios follow the ALU_MUL_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_;
  logic             in_valid;
  logic             in_ready;
  alu_op_t          op;
  logic [WIDTH-1:0] accum;
  logic [WIDTH-1:0] data;
  logic             zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             res_zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .accum     (accum),
    .data      (data),
    .zero      (zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .res_zero  (res_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request and returns #1 after the edge that takes it.
  task automatic issue(input alu_op_t o, input logic [7:0] a, input logic [7:0] b);
    op = o; accum = a; data = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_ = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = PASS_A; accum = 8'h01; data = 8'h00;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out !== 8'h00) begin n_errors++; $display("FAIL reset_out got=%h exp=00", out); end
    n_checks++; if (carry !== 1'b0 || res_zero !== 1'b0) begin n_errors++; $display("FAIL reset_flags got=%b%b exp=00", carry, res_zero); end
    @(negedge clk); rst_ = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    issue(ADD, 8'hF0, 8'h20);
    n_checks++; if (out_valid !== 1'b1 || out !== 8'h10 || carry !== 1'b1 || res_zero !== 1'b0)
      begin n_errors++; $display("FAIL add got v=%b out=%h c=%b z=%b exp v=1 out=10 c=1 z=0", out_valid, out, carry, res_zero); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL add_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sub;
    issue(SUB, 8'h05, 8'h07);
    n_checks++; if (out !== 8'hFE || carry !== 1'b1 || res_zero !== 1'b0)
      begin n_errors++; $display("FAIL sub_borrow got out=%h c=%b z=%b exp out=fe c=1 z=0", out, carry, res_zero); end
    @(posedge clk); #1;
    issue(SUB, 8'h07, 8'h07);
    n_checks++; if (out !== 8'h00 || carry !== 1'b0 || res_zero !== 1'b1)
      begin n_errors++; $display("FAIL sub_zero got out=%h c=%b z=%b exp out=00 c=0 z=1", out, carry, res_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_logic;
    alu_op_t    ops  [6];
    logic [7:0] av   [6];
    logic [7:0] bv   [6];
    logic [7:0] ev   [6];
    ops[0] = AND;             av[0] = 8'hF0; bv[0] = 8'h3C; ev[0] = 8'h30;
    ops[1] = OR;              av[1] = 8'hF0; bv[1] = 8'h0C; ev[1] = 8'hFC;
    ops[2] = PASS_A;          av[2] = 8'h5A; bv[2] = 8'hFF; ev[2] = 8'h5A;
    ops[3] = PASS_B;          av[3] = 8'h5A; bv[3] = 8'hA5; ev[3] = 8'hA5;
    ops[4] = alu_op_t'(4'hC); av[4] = 8'h77; bv[4] = 8'h11; ev[4] = 8'h77;
    ops[5] = AND;             av[5] = 8'h0F; bv[5] = 8'hF0; ev[5] = 8'h00;
    // Leave carry set beforehand so carry=0 is a real observation
    issue(ADD, 8'hFF, 8'h01);
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], av[i], bv[i]);
      n_checks++; if (out !== ev[i] || carry !== 1'b0 || res_zero !== (ev[i] == 8'h00))
        begin n_errors++; $display("FAIL logic[%0d] got out=%h c=%b z=%b exp out=%h c=0 z=%b", i, out, carry, res_zero, ev[i], ev[i] == 8'h00); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold;
    out_ready = 1'b0;
    issue(XOR, 8'hAA, 8'h55);
    op = ADD; accum = 8'h01; data = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out !== 8'hFF || in_ready !== 1'b0)
        begin n_errors++; $display("FAIL hold[%0d] got v=%b out=%h rdy=%b exp v=1 out=ff rdy=0", i, out_valid, out, in_ready); end
      @(posedge clk); #1;
    end
    n_checks++; if (out !== 8'hFF) begin n_errors++; $display("FAIL hold_end got=%h exp=ff", out); end
    out_ready = 1'b1; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL hold_release_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out !== 8'h02)
      begin n_errors++; $display("FAIL hold_queued got v=%b out=%h exp v=1 out=02", out_valid, out); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_o [3];
    exp_o[0] = 8'h03; exp_o[1] = 8'h0F; exp_o[2] = 8'hF0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin op = ADD; accum = 8'h01; data = 8'h02; end
        1: begin op = SUB; accum = 8'h10; data = 8'h01; end
        default: begin op = XOR; accum = 8'hFF; data = 8'h0F; end
      endcase
      in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || out !== exp_o[i] || carry !== 1'b0)
        begin n_errors++; $display("FAIL b2b[%0d] got v=%b out=%h c=%b exp v=1 out=%h c=0", i, out_valid, out, carry, exp_o[i]); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_zero;
    accum = 8'h00; #1;
    n_checks++; if (zero !== 1'b1) begin n_errors++; $display("FAIL zero_idle got=%b exp=1", zero); end
    accum = 8'h01; #1;
    n_checks++; if (zero !== 1'b0) begin n_errors++; $display("FAIL zero_nz got=%b exp=0", zero); end
    out_ready = 1'b0;
    issue(PASS_A, 8'h01, 8'h00);
    accum = 8'h00; #1;
    n_checks++; if (zero !== 1'b1 || out !== 8'h01) begin n_errors++; $display("FAIL zero_hold got z=%b out=%h exp z=1 out=01", zero, out); end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    int n;
`ifdef ALU_MUL_EN
    out_ready = 1'b1;
    issue(MUL, 8'h0F, 8'h11);
    accum = 8'h00; #1;
    n_checks++; if (zero !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0)
      begin n_errors++; $display("FAIL mul_calc got z=%b rdy=%b v=%b exp z=1 rdy=0 v=0", zero, in_ready, out_valid); end
    op = ADD; accum = 8'h03; data = 8'h04; in_valid = 1'b1;
    n = 1;
    @(posedge clk); #1;
    while (out_valid !== 1'b1 && n < 40) begin
      n++; @(posedge clk); #1;
    end
    n_checks++; if (n !== 9) begin n_errors++; $display("FAIL mul_latency got=%0d exp=9", n); end
    n_checks++; if (out !== 8'hFF || carry !== 1'b0 || res_zero !== 1'b0)
      begin n_errors++; $display("FAIL mul_0f_11 got out=%h c=%b z=%b exp out=ff c=0 z=0", out, carry, res_zero); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out !== 8'h07 || out_valid !== 1'b1)
      begin n_errors++; $display("FAIL mul_then_add got v=%b out=%h exp v=1 out=07", out_valid, out); end
    @(posedge clk); #1;
    issue(MUL, 8'h10, 8'h10);
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    n_checks++; if (n !== 10 || out !== 8'h00 || carry !== 1'b1 || res_zero !== 1'b1)
      begin n_errors++; $display("FAIL mul_10_10 got n=%0d out=%h c=%b z=%b exp n=10 out=00 c=1 z=1", n, out, carry, res_zero); end
    @(posedge clk); #1;
`else
    n = 0;
    out_ready = 1'b1;
    issue(ADD, 8'hFF, 8'h01);
    issue(MUL, 8'h0F, 8'h11);
    if (out_valid === 1'b1) n = 1;
    n_checks++; if (n !== 1 || out !== 8'h0F || carry !== 1'b0)
      begin n_errors++; $display("FAIL mul_disabled got v=%0d out=%h c=%b exp v=1 out=0f c=0", n, out, carry); end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset_inflight;
    int stale;
    out_ready = 1'b0;
    issue(ADD, 8'h11, 8'h22);
    n_checks++; if (out_valid !== 1'b1 || out !== 8'h33) begin n_errors++; $display("FAIL rst_hold_pre got v=%b out=%h exp v=1 out=33", out_valid, out); end
    rst_ = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b0 || out !== 8'h00 || res_zero !== 1'b0)
      begin n_errors++; $display("FAIL rst_hold got v=%b out=%h z=%b exp v=0 out=00 z=0", out_valid, out, res_zero); end
    @(negedge clk); rst_ = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_hold_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
`ifdef ALU_MUL_EN
    issue(PASS_A, 8'h3C, 8'h00);
    @(posedge clk); #1;
    issue(MUL, 8'h03, 8'h05);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b0 || out !== 8'h00 || in_ready !== 1'b1)
      begin n_errors++; $display("FAIL rst_calc got v=%b out=%h rdy=%b exp v=0 out=00 rdy=1", out_valid, out, in_ready); end
    @(negedge clk); rst_ = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_calc_ready got=%b exp=1", in_ready); end
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0 || out !== 8'h00) stale++;
      @(posedge clk); #1;
    end
    n_checks++; if (stale !== 0) begin n_errors++; $display("FAIL rst_calc_stale got=%0d cycles exp=0", stale); end
`else
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0 || out !== 8'h00) stale++;
      @(posedge clk); #1;
    end
    n_checks++; if (stale !== 0) begin n_errors++; $display("FAIL rst_hold_stale got=%0d cycles exp=0", stale); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_hold();
    test_back_to_back();
    test_zero();
    test_mul();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
